// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer: FSM state encoding and the
// bit-counter width helper.
package bit_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_PAR   = 2'b10
    } state_t;

    // Width of a counter that indexes 0..width-1 (at least one bit).
    function automatic int COUNT_W(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Load handshake plus serial output bundle of the bit serializer.
// master = word producer / serial consumer side, slave = the serializer.
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             serial_out;
    logic             serial_valid;
    logic             frame_done;

    modport master (
        output data_in, load_valid,
        input  load_ready, serial_out, serial_valid, frame_done
    );

    modport slave (
        input  data_in, load_valid,
        output load_ready, serial_out, serial_valid, frame_done
    );
endinterface

// File: rtl/ser_bit_counter.sv
// Modulo-WIDTH bit counter with synchronous clear (dominant) and enable.
// last flags the final bit position of a data frame.
module ser_bit_counter
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = COUNT_W(WIDTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          last
);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [CW-1:0] count_reg, count_next;

    // Next count: clear wins, otherwise advance and wrap after the last bit.
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable) begin
            count_next = (count_reg == LAST_IDX) ? '0 : count_reg + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
    assign last  = (count_reg == LAST_IDX);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: accepts WIDTH-bit words on a valid/ready load
// handshake and emits them one bit per clock, gap-free when words arrive
// back to back. Optional even-parity bit per frame when the macro
// BIT_SERIALIZER_PARITY_EN is defined.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    bit_serializer_if.slave  bus
);
    localparam int            CW         = COUNT_W(WIDTH);
    localparam logic [CW-1:0] PENULT_IDX = CW'(WIDTH - 2);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [CW-1:0]    count;
    logic             count_last;
    logic             load_ready;
    logic             accept;
    logic             lead_bit;
    logic             serial_out_reg,   serial_out_next;
    logic             serial_valid_reg, serial_valid_next;
    logic             frame_done_reg,   frame_done_next;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             parity_reg, parity_next;
`endif

    ser_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept),
        .enable (state_reg == ST_SHIFT),
        .count  (count),
        .last   (count_last)
    );

    // Ready in idle and on the final bit cycle of a frame, so a new word can
    // follow the last bit with no gap.
    always_comb begin
        load_ready = (state_reg == ST_IDLE);
`ifdef BIT_SERIALIZER_PARITY_EN
        load_ready = load_ready | (state_reg == ST_PAR);
`else
        load_ready = load_ready | ((state_reg == ST_SHIFT) && count_last);
`endif
    end

    assign accept = bus.load_valid & load_ready;

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (count_last) begin
`ifdef BIT_SERIALIZER_PARITY_EN
                    state_next = ST_PAR;
`else
                    state_next = accept ? ST_SHIFT : ST_IDLE;
`endif
                end
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            ST_PAR: begin
                state_next = accept ? ST_SHIFT : ST_IDLE;
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: load or shift, then derive the registered output values for
    // the cycle that follows this edge.
    always_comb begin
        shift_next = shift_reg;
        if (accept) begin
            shift_next = bus.data_in;
        end else if (state_reg == ST_SHIFT) begin
            if (MSB_FIRST) shift_next = {shift_reg[WIDTH-2:0], 1'b0};
            else           shift_next = {1'b0, shift_reg[WIDTH-1:1]};
        end
        lead_bit = MSB_FIRST ? shift_next[WIDTH-1] : shift_next[0];

        serial_valid_next = (state_next != ST_IDLE);
        serial_out_next   = IDLE_LEVEL;
        if (state_next == ST_SHIFT) serial_out_next = lead_bit;
`ifdef BIT_SERIALIZER_PARITY_EN
        parity_next = accept ? ^bus.data_in : parity_reg;
        if (state_next == ST_PAR) serial_out_next = parity_next;
        frame_done_next = (state_next == ST_PAR);
`else
        // Second-to-last bit showing now means the last one shows next.
        frame_done_next = (state_reg == ST_SHIFT) && (count == PENULT_IDX);
`endif
    end

    // State, shift register and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            shift_reg        <= '0;
            serial_out_reg   <= IDLE_LEVEL;
            serial_valid_reg <= 1'b0;
            frame_done_reg   <= 1'b0;
        end else begin
            state_reg        <= state_next;
            shift_reg        <= shift_next;
            serial_out_reg   <= serial_out_next;
            serial_valid_reg <= serial_valid_next;
            frame_done_reg   <= frame_done_next;
        end
    end

`ifdef BIT_SERIALIZER_PARITY_EN
    // Parity of the captured word, sent after the data bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) parity_reg <= 1'b0;
        else       parity_reg <= parity_next;
    end
`endif

    assign bus.load_ready   = load_ready;
    assign bus.serial_out   = serial_out_reg;
    assign bus.serial_valid = serial_valid_reg;
    assign bus.frame_done   = frame_done_reg;

endmodule

// File: tb/tb_bit_serializer.sv
// Testbench for bit_serializer: one MSB-first and one LSB-first instance,
// directed table vectors, hand-written multi-cycle sequences and random
// traffic against a bit-queue reference model. Honours the
// BIT_SERIALIZER_PARITY_EN macro for frame length and parity bit.
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    bit_serializer_if #(.WIDTH(8)) if0 ();
    bit_serializer_if #(.WIDTH(8)) if1 ();

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (
        .clock (clock),
        .reset (reset),
        .bus   (if0)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
        .clock (clock),
        .reset (reset),
        .bus   (if1)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per instance, a list of bits still to appear on the
    // line (bit 0 = the one showing now) and the matching end-of-frame flags.
    logic [31:0] pend  [2];
    logic [31:0] plast [2];
    int          plen  [2];

    typedef struct {
        int         inst;
        logic [7:0] word;
        logic [7:0] seq;   // expected data bits, leftmost sent first
        logic       par;
    } vec_t;

    vec_t vt [5];

    function automatic logic [3:0] act_vec(input int k);
        if (k == 0) return {if0.load_ready, if0.serial_valid, if0.serial_out, if0.frame_done};
        return {if1.load_ready, if1.serial_valid, if1.serial_out, if1.frame_done};
    endfunction

    function automatic logic [3:0] exp_vec(input int k);
        logic r, v, o, d;
        r = (plen[k] <= 1);
        v = (plen[k] > 0);
        o = v ? pend[k][0] : 1'b0;
        d = v ? plast[k][0] : 1'b0;
        return {r, v, o, d};
    endfunction

    function automatic logic frame_bit(input logic [7:0] w, input bit msb, input int i);
        if (i >= 8) return ^w;
        return msb ? w[7-i] : w[i];
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input int k, input logic lv, input logic [7:0] d);
        logic acc;
        if (reset) begin
            pend[k] = '0; plast[k] = '0; plen[k] = 0;
            return;
        end
        acc = lv && (plen[k] <= 1);
        if (plen[k] > 0) begin
            pend[k]  = pend[k] >> 1;
            plast[k] = plast[k] >> 1;
            plen[k]--;
        end
        if (acc) begin
            for (int i = 0; i < FL; i++) begin
                pend[k][plen[k]+i]  = frame_bit(d, (k == 0), i);
                plast[k][plen[k]+i] = (i == FL - 1);
            end
            plen[k] += FL;
        end
    endtask

    // Called at a falling edge: drive, clock once, update model, compare.
    task automatic tick(input logic lv0, input logic [7:0] d0,
                        input logic lv1, input logic [7:0] d1);
        if0.load_valid = lv0; if0.data_in = d0;
        if1.load_valid = lv1; if1.data_in = d1;
        @(posedge clock);
        model_edge(0, lv0, d0);
        model_edge(1, lv1, d1);
        @(negedge clock);
        check("model_msb", act_vec(0), exp_vec(0));
        check("model_lsb", act_vec(1), exp_vec(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [3:0] a;
        logic       eb;
        logic       cv [2];
        logic [7:0] cd [2];
        logic       rdy0, rdy1;

        vt[0] = '{0, 8'hB0, 8'b10110000, 1'b1};
        vt[1] = '{1, 8'h0D, 8'b10110000, 1'b1};
        vt[2] = '{0, 8'hA5, 8'b10100101, 1'b0};
        vt[3] = '{0, 8'h81, 8'b10000001, 1'b0};
        vt[4] = '{1, 8'h3C, 8'b00111100, 1'b0};

        for (int k = 0; k < 2; k++) begin
            pend[k] = '0; plast[k] = '0; plen[k] = 0;
            cv[k] = 1'b0; cd[k] = 8'h00;
        end
        if0.load_valid = 1'b0; if0.data_in = 8'h00;
        if1.load_valid = 1'b0; if1.data_in = 8'h00;
        reset = 1'b1;
        @(negedge clock);

        // Reset held two cycles with no load requests.
        for (int r = 0; r < 2; r++) begin
            check("reset_msb", act_vec(0), 4'b1000);
            check("reset_lsb", act_vec(1), 4'b1000);
            tick(1'b0, 8'h00, 1'b0, 8'h00);
        end
        reset = 1'b0;
        tick(1'b0, 8'h00, 1'b0, 8'h00);

        // Back-to-back A5 then 3C with load_valid held on the MSB instance.
        tick(1'b1, 8'hA5, 1'b0, 8'h00);
        for (int c = 1; c <= 2 * FL; c++) begin
            a = act_vec(0);
            check("b2b_valid", {3'b0, a[2]}, 4'b0001);
            check("b2b_done", {3'b0, a[0]}, {3'b0, (c == FL) || (c == 2 * FL)});
            if (c == FL)     check("b2b_ready_last", {3'b0, a[3]}, 4'b0001);
            if (c == FL - 1) check("b2b_ready_busy", {3'b0, a[3]}, 4'b0000);
            tick(c <= FL, 8'h3C, 1'b0, 8'h00);
        end
        check("b2b_idle", act_vec(0), 4'b1000);

        // Reset in the middle of an FF frame aborts it immediately.
        tick(1'b1, 8'hFF, 1'b0, 8'h00);
        for (int c = 0; c < 3; c++) tick(1'b0, 8'h00, 1'b0, 8'h00);
        check("midframe_pre", act_vec(0), 4'b0110);
        reset = 1'b1;
        #1;
        check("midframe_reset", act_vec(0), 4'b1000);
        tick(1'b0, 8'h00, 1'b0, 8'h00);
        reset = 1'b0;

        // Directed single-frame vectors, checked bit by bit.
        for (int v = 0; v < 5; v++) begin
            tick(vt[v].inst == 0, vt[v].word, vt[v].inst == 1, vt[v].word);
            for (int i = 0; i < FL; i++) begin
                a  = act_vec(vt[v].inst);
                eb = (i < 8) ? vt[v].seq[7-i] : vt[v].par;
                check($sformatf("vec%0d_bit%0d", v, i), a[2:0], {1'b1, eb, (i == FL - 1)});
                tick(1'b0, 8'h00, 1'b0, 8'h00);
            end
            check($sformatf("vec%0d_idle", v), act_vec(vt[v].inst), 4'b1000);
        end

        // Random traffic; a presented word is held until it is accepted.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (!cv[k]) begin
                    cv[k] = ($urandom_range(0, 9) < 6);
                    cd[k] = 8'($urandom);
                end
            end
            rdy0 = (plen[0] <= 1);
            rdy1 = (plen[1] <= 1);
            tick(cv[0], cd[0], cv[1], cd[1]);
            if (cv[0] && rdy0) cv[0] = 1'b0;
            if (cv[1] && rdy1) cv[1] = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
